// File: rtl/axi4lite_sa_cache.sv
// N-way set-associative write-back/write-allocate cache with an AXI4-Lite memory port.
// Lines move one single-beat transaction per word; NUM_SETS and words per line are assumed >= 2.
module axi4lite_sa_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_valid_i,
    output logic                    core_req_ready_o,
    input  logic                    core_req_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_req_wstrb_i,
    output logic                    core_resp_valid_o,
    input  logic                    core_resp_ready_i,
    output logic [DATA_WIDTH-1:0]   core_resp_rdata_o,
    output logic                    core_resp_err_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    input  logic [1:0]              m_bresp_i,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_OFF = $clog2(STRB_W);
    localparam int OFF_W    = $clog2(LINE_BYTES);
    localparam int WORDS    = LINE_BYTES / STRB_W;
    localparam int WORD_W   = $clog2(WORDS);
    localparam int IDX_W    = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_ADDR, WB_RESP, RF_ADDR, RF_DATA, RESP} state_e;

    logic                  valid_q [NUM_WAYS][NUM_SETS];
    logic                  dirty_q [NUM_WAYS][NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS][WORDS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];

    state_e                state_q;
    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [STRB_W-1:0]     req_wstrb_q;
    logic [WORD_W-1:0]     word_q;
    logic [WAY_W-1:0]      victim_q;
    logic                  err_q, rf_err_q;
    logic                  req_ready_q, resp_valid_q, resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_W-1:0]     req_word, word_nxt;
    logic                  hit, victim_inv, fill_err;
    logic [WAY_W-1:0]      hit_way, victim_d;
    logic [DATA_WIDTH-1:0] line_word;

    assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx   = req_addr_q[OFF_W +: IDX_W];
    assign req_word  = req_addr_q[BYTE_OFF +: WORD_W];
    assign word_nxt  = word_q + 1'b1;
    assign fill_err  = rf_err_q | (m_rresp_i != 2'b00);
    // On the final refill beat the requested word may still be on the R channel.
    assign line_word = (req_word == word_q) ? m_rdata_i : data_q[victim_q][req_idx][req_word];

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic [STRB_W-1:0]     st);
        merge = old;
        for (int b = 0; b < STRB_W; b++)
            if (st[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [TAG_W-1:0]  t,
                                                        input logic [IDX_W-1:0]  i,
                                                        input logic [WORD_W-1:0] w);
        word_addr = {t, i, w, {BYTE_OFF{1'b0}}};
    endfunction

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_inv = 1'b0;
        victim_d   = rr_q[req_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][req_idx]) begin
                victim_inv = 1'b1;
                victim_d   = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
            word_q       <= '0;
            victim_q     <= '0;
            err_q        <= 1'b0;
            rf_err_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                    for (int k = 0; k < WORDS; k++) data_q[w][s][k] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: if (core_req_valid_i) begin
                    req_we_q    <= core_req_we_i;
                    req_addr_q  <= core_req_addr_i;
                    req_wdata_q <= core_req_wdata_i;
                    req_wstrb_q <= core_req_wstrb_i;
                    err_q       <= 1'b0;
                    rf_err_q    <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= LOOKUP;
                end
                LOOKUP: begin
                    word_q <= '0;
                    if (hit) begin
                        if (req_we_q) begin
                            data_q[hit_way][req_idx][req_word] <=
                                merge(data_q[hit_way][req_idx][req_word], req_wdata_q, req_wstrb_q);
                            dirty_q[hit_way][req_idx] <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            resp_rdata_q <= data_q[hit_way][req_idx][req_word];
                        end
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        victim_q <= victim_d;
                        if (!victim_inv)
                            rr_q[req_idx] <= (NUM_WAYS == 1) ? '0 : rr_q[req_idx] + 1'b1;
                        if (valid_q[victim_d][req_idx] && dirty_q[victim_d][req_idx]) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= word_addr(tag_q[victim_d][req_idx], req_idx, '0);
                            wdata_q   <= data_q[victim_d][req_idx][0];
                            state_q   <= WB_ADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= word_addr(req_tag, req_idx, '0);
                            state_q   <= RF_ADDR;
                        end
                    end
                end
                WB_ADDR: begin
                    if (m_awready_i) awvalid_q <= 1'b0;
                    if (m_wready_i)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m_awready_i) && (!wvalid_q || m_wready_i)) begin
                        bready_q <= 1'b1;
                        state_q  <= WB_RESP;
                    end
                end
                WB_RESP: if (m_bvalid_i) begin
                    bready_q <= 1'b0;
                    if (m_bresp_i != 2'b00) err_q <= 1'b1;
                    if (word_q == LAST_WORD) begin
                        word_q    <= '0;
                        arvalid_q <= 1'b1;
                        araddr_q  <= word_addr(req_tag, req_idx, '0);
                        state_q   <= RF_ADDR;
                    end else begin
                        word_q    <= word_nxt;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= word_addr(tag_q[victim_q][req_idx], req_idx, word_nxt);
                        wdata_q   <= data_q[victim_q][req_idx][word_nxt];
                        state_q   <= WB_ADDR;
                    end
                end
                RF_ADDR: if (m_arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RF_DATA;
                end
                RF_DATA: if (m_rvalid_i) begin
                    rready_q <= 1'b0;
                    data_q[victim_q][req_idx][word_q] <= m_rdata_i;
                    rf_err_q <= fill_err;
                    if (word_q != LAST_WORD) begin
                        word_q    <= word_nxt;
                        arvalid_q <= 1'b1;
                        araddr_q  <= word_addr(req_tag, req_idx, word_nxt);
                        state_q   <= RF_ADDR;
                    end else begin
                        resp_err_q   <= err_q | fill_err;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                        if (fill_err) begin
                            valid_q[victim_q][req_idx] <= 1'b0;
                            dirty_q[victim_q][req_idx] <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            valid_q[victim_q][req_idx] <= 1'b1;
                            dirty_q[victim_q][req_idx] <= req_we_q;
                            tag_q[victim_q][req_idx]   <= req_tag;
                            if (req_we_q) begin
                                data_q[victim_q][req_idx][req_word] <=
                                    merge(line_word, req_wdata_q, req_wstrb_q);
                                resp_rdata_q <= '0;
                            end else begin
                                resp_rdata_q <= err_q ? '0 : line_word;
                            end
                        end
                    end
                end
                RESP: if (core_resp_ready_i) begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_req_ready_o  = req_ready_q;
    assign core_resp_valid_o = resp_valid_q;
    assign core_resp_rdata_o = resp_rdata_q;
    assign core_resp_err_o   = resp_err_q;
    assign m_awvalid_o       = awvalid_q;
    assign m_awaddr_o        = awaddr_q;
    assign m_wvalid_o        = wvalid_q;
    assign m_wdata_o         = wdata_q;
    assign m_wstrb_o         = '1;
    assign m_bready_o        = bready_q;
    assign m_arvalid_o       = arvalid_q;
    assign m_araddr_o        = araddr_q;
    assign m_rready_o        = rready_q;
endmodule

// File: tb/tb_axi4lite_sa_cache.sv
// Directed bench for axi4lite_sa_cache with a small AXI4-Lite memory slave.
// Memory word at byte address a holds 0x50000000|a except the two seeded words.
module tb_axi4lite_sa_cache;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid, reqReady, reqWe;
    logic [31:0] reqAddr, reqWdata;
    logic [3:0]  reqWstrb;
    logic        respValid, respReady, respErr;
    logic [31:0] respRdata;
    logic        awValid, awReady, wValid, wReady, bValid, bReady;
    logic        arValid, arReady, rValid, rReady;
    logic [31:0] awAddr, wData, arAddr, rData;
    logic [3:0]  wStrb;
    logic [1:0]  bResp, rResp;

    int testCount = 0;
    int failCount = 0;
    int cycleCnt = 0;
    int tStart = 0;
    int awStallReq = 0;
    int rErrAt = -1;
    int awWaitCnt, arCnt = 0, awCnt = 0, wLogCnt = 0;
    int wBeforeAw = 0, wAfterHs = 0, awUnstable = 0, bEarly = 0;
    logic [31:0] mem [0:8191];
    logic [31:0] arLog [0:255];
    int          arEdge [0:255];
    logic [31:0] awLog [0:255];
    logic [31:0] wLog [0:255];
    logic        awGot, wGot, awStalledPrev;
    logic [31:0] awAddrLat, wDataLat, awAddrPrev, wrAddr, wrData;
    logic        awHs, wHs;

    always #5 clock = ~clock;

    axi4lite_sa_cache dut (
        .clk(clock), .rst(reset),
        .core_req_valid_i(reqValid), .core_req_ready_o(reqReady), .core_req_we_i(reqWe),
        .core_req_addr_i(reqAddr), .core_req_wdata_i(reqWdata), .core_req_wstrb_i(reqWstrb),
        .core_resp_valid_o(respValid), .core_resp_ready_i(respReady),
        .core_resp_rdata_o(respRdata), .core_resp_err_o(respErr),
        .m_awvalid_o(awValid), .m_awready_i(awReady), .m_awaddr_o(awAddr),
        .m_wvalid_o(wValid), .m_wready_i(wReady), .m_wdata_o(wData), .m_wstrb_o(wStrb),
        .m_bvalid_i(bValid), .m_bready_o(bReady), .m_bresp_i(bResp),
        .m_arvalid_o(arValid), .m_arready_i(arReady), .m_araddr_o(arAddr),
        .m_rvalid_i(rValid), .m_rready_o(rReady), .m_rdata_i(rData), .m_rresp_i(rResp)
    );

    assign awReady = (awWaitCnt >= awStallReq);
    assign wReady  = 1'b1;
    assign arReady = 1'b1;
    assign awHs    = awValid && awReady;
    assign wHs     = wValid && wReady;
    assign wrAddr  = awHs ? awAddr : awAddrLat;
    assign wrData  = wHs ? wData : wDataLat;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Memory slave: B one cycle after both AW and W, R one cycle after AR.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bValid <= 1'b0; bResp <= 2'b00;
            rValid <= 1'b0; rResp <= 2'b00; rData <= '0;
            awGot <= 1'b0; wGot <= 1'b0; awWaitCnt <= 0; awStalledPrev <= 1'b0;
            awAddrLat <= '0; wDataLat <= '0; awAddrPrev <= '0;
            for (int i = 0; i < 8192; i++) mem[i] <= 32'h5000_0000 | 32'(i * 4);
            mem[13'h0401] <= 32'hDEAD_BEEF;
            mem[13'h0402] <= 32'hAABB_CCDD;
        end else begin
            awStalledPrev <= awValid && !awReady;
            awAddrPrev    <= awAddr;
            if (awStalledPrev && (!awValid || awAddr != awAddrPrev)) awUnstable <= awUnstable + 1;
            if (bReady && (awValid || wValid)) bEarly <= bEarly + 1;
            if (wValid && wGot) wAfterHs <= wAfterHs + 1;
            if (awValid && !awReady) awWaitCnt <= awWaitCnt + 1;
            if (awHs) begin
                awWaitCnt <= 0;
                awLog[awCnt] <= awAddr;
                awCnt <= awCnt + 1;
            end
            if (wHs) begin
                wLog[wLogCnt] <= wData;
                wLogCnt <= wLogCnt + 1;
                if (!awGot && !awHs) wBeforeAw <= wBeforeAw + 1;
            end
            if (bValid && bReady) bValid <= 1'b0;
            if ((awGot || awHs) && (wGot || wHs)) begin
                mem[wrAddr[14:2]] <= wrData;
                bValid <= 1'b1;
                bResp  <= 2'b00;
                awGot  <= 1'b0;
                wGot   <= 1'b0;
            end else begin
                if (awHs) begin awGot <= 1'b1; awAddrLat <= awAddr; end
                if (wHs)  begin wGot  <= 1'b1; wDataLat  <= wData;  end
            end
            if (rValid && rReady) rValid <= 1'b0;
            if (arValid && arReady) begin
                arLog[arCnt]  <= arAddr;
                arEdge[arCnt] <= cycleCnt + 1;
                arCnt  <= arCnt + 1;
                rValid <= 1'b1;
                rData  <= mem[arAddr[14:2]];
                rResp  <= (arCnt == rErrAt) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request and waits (bounded) for its response; latency is in spec cycle numbering.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] rd, output logic err,
                                 output int lat);
        @(negedge clock);
        reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqWstrb = wstrb;
        if (!reqReady) checkOutput("req_ready_idle", reqReady, 1);
        @(negedge clock);
        tStart = cycleCnt;
        reqValid = 1'b0;
        lat = -1; rd = '0; err = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (respValid) begin
                rd = respRdata; err = respErr; lat = cycleCnt + 1 - tStart;
                break;
            end
            @(negedge clock);
        end
        if (lat < 0) checkOutput("resp_timeout", 0, 1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, arBase, awBase, wBase;

    initial begin
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqWstrb = '0;
        respReady = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_outputs", {reqReady, respValid, respErr, awValid, wValid, bReady, arValid, rReady}, 8'b1000_0000);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_reset_outputs", {reqReady, respValid, respErr, awValid, wValid, bReady, arValid, rReady}, 8'b1000_0000);
        checkOutput("post_reset_rdata", respRdata, 0);

        arBase = arCnt;
        applyStimulus(1'b0, 32'h1004, 0, 0, rd, er, lat);
        checkOutput("miss_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("miss_err", er, 0);
        checkOutput("miss_latency", lat, 10);
        checkOutput("miss_ar_count", arCnt - arBase, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("miss_araddr%0d", k), arLog[arBase + k], 32'h1000 + 4 * k);
            checkOutput($sformatf("miss_ar_cycle%0d", k), arEdge[arBase + k] - tStart, 2 + 2 * k);
        end

        arBase = arCnt;
        applyStimulus(1'b0, 32'h1004, 0, 0, rd, er, lat);
        checkOutput("hit_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("hit_latency", lat, 2);
        checkOutput("hit_no_ar", arCnt - arBase, 0);

        arBase = arCnt; awBase = awCnt;
        applyStimulus(1'b1, 32'h1008, 32'h1122_3344, 4'b0011, rd, er, lat);
        checkOutput("wr_hit_latency", lat, 2);
        checkOutput("wr_hit_rdata", rd, 0);
        checkOutput("wr_hit_no_axi", (arCnt - arBase) + (awCnt - awBase), 0);
        applyStimulus(1'b0, 32'h1008, 0, 0, rd, er, lat);
        checkOutput("wr_merge_rdata", rd, 32'hAABB_3344);

        applyStimulus(1'b0, 32'h2000, 0, 0, rd, er, lat);
        checkOutput("way1_fill_rdata", rd, 32'h5000_2000);
        checkOutput("way1_fill_latency", lat, 10);

        awStallReq = 3;
        arBase = arCnt; awBase = awCnt; wBase = wLogCnt;
        applyStimulus(1'b0, 32'h3000, 0, 0, rd, er, lat);
        awStallReq = 0;
        checkOutput("evict_rdata", rd, 32'h5000_3000);
        checkOutput("evict_latency", lat, 30);
        checkOutput("evict_aw_count", awCnt - awBase, 4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("evict_awaddr%0d", k), awLog[awBase + k], 32'h1000 + 4 * k);
        checkOutput("evict_wdata0", wLog[wBase + 0], 32'h5000_1000);
        checkOutput("evict_wdata1", wLog[wBase + 1], 32'hDEAD_BEEF);
        checkOutput("evict_wdata2", wLog[wBase + 2], 32'hAABB_3344);
        checkOutput("evict_wdata3", wLog[wBase + 3], 32'h5000_100C);
        checkOutput("evict_araddr0", arLog[arBase], 32'h3000);
        checkOutput("evict_araddr3", arLog[arBase + 3], 32'h300C);
        checkOutput("w_before_aw", wBeforeAw, 4);
        checkOutput("w_drop_after_hs", wAfterHs, 0);
        checkOutput("aw_stable_stall", awUnstable, 0);
        checkOutput("b_ready_early", bEarly, 0);
        checkOutput("mem_written_back", mem[13'h0402], 32'hAABB_3344);

        awBase = awCnt; arBase = arCnt;
        applyStimulus(1'b0, 32'h4000, 0, 0, rd, er, lat);
        checkOutput("rr_evict_rdata", rd, 32'h5000_4000);
        checkOutput("rr_evict_latency", lat, 10);
        checkOutput("rr_evict_no_wb", awCnt - awBase, 0);
        checkOutput("rr_evict_araddr", arLog[arBase], 32'h4000);
        applyStimulus(1'b0, 32'h3004, 0, 0, rd, er, lat);
        checkOutput("kept_way_hit", {lat[7:0], rd}, {8'd2, 32'h5000_3004});

        applyStimulus(1'b1, 32'h1014, 32'hCAFE_F00D, 4'b1111, rd, er, lat);
        checkOutput("wr_alloc_latency", lat, 10);
        checkOutput("wr_alloc_rdata", rd, 0);
        applyStimulus(1'b0, 32'h1014, 0, 0, rd, er, lat);
        checkOutput("wr_alloc_readback", {lat[7:0], rd}, {8'd2, 32'hCAFE_F00D});

        rErrAt = arCnt + 2;
        arBase = arCnt;
        applyStimulus(1'b0, 32'h5008, 0, 0, rd, er, lat);
        rErrAt = -1;
        checkOutput("rf_err_flag", er, 1);
        checkOutput("rf_err_rdata", rd, 0);
        checkOutput("rf_err_all_beats", arCnt - arBase, 4);
        arBase = arCnt;
        applyStimulus(1'b0, 32'h5008, 0, 0, rd, er, lat);
        checkOutput("rf_err_refetch", {er, lat[7:0], rd}, {1'b0, 8'd10, 32'h5000_5008});
        checkOutput("rf_err_refetch_ar", arCnt - arBase, 4);

        @(negedge clock);
        reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h6000;
        @(negedge clock);
        reqValid = 1'b0;
        for (int i = 0; i < 50 && !rReady; i++) @(negedge clock);
        checkOutput("reached_rf_data", rReady, 1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_outputs", {arValid, rReady, respValid, reqReady}, 4'b0001);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h1014, 0, 0, rd, er, lat);
        checkOutput("post_reset_miss", {lat[7:0], rd}, {8'd10, 32'h5000_1014});

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
